psum_acc: RTL and testbench



---
 rtl/psum_pkg.sv | 23 ++
 rtl/psum_bank.sv | 29 ++
 rtl/psum_acc.sv | 142 ++++++++++++++
 tb/tb_psum_acc.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_pkg.sv
// Shared parameters and types for the partial-sum accumulator.
`timescale 1ns/1ps
package psum_pkg;
    localparam int TILE_LEN   = 16;
    localparam int ROWS       = 8;
    localparam int PSUM_WIDTH = 24;
    localparam int MARK_LAT   = 3;
    localparam int COL_W      = $clog2(TILE_LEN);
    localparam int CNT_W      = COL_W + 1;

    typedef logic [ROWS-1:0][PSUM_WIDTH-1:0] psum_beat_t;

    typedef struct packed {
        logic cv;
        logic oc;
        logic ic;
    } mark_t;

    typedef enum logic {
        D_IDLE  = 1'b0,
        D_DRAIN = 1'b1
    } drain_st_t;
endpackage

// File: rtl/psum_bank.sv
// One TILE_LEN-deep bank of partial-sum beats: overwrite/accumulate write
// port plus an independent combinational read port.
`timescale 1ns/1ps
module psum_bank
    import psum_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic             acc,
    input  logic [COL_W-1:0] waddr,
    input  psum_beat_t       wdata,
    input  logic [COL_W-1:0] raddr,
    output psum_beat_t       rdata
);
    psum_beat_t mem [TILE_LEN];
    psum_beat_t sum;

    // per-row wrap-around add; no saturation
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        assign sum[r] = mem[waddr][r] + wdata[r];
    end

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= acc ? sum : wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/psum_acc.sv
// Partial-sum accumulator: accumulates PE-array beats over input-channel
// passes into a working bank and drains the finished bank over valid/ready.
`timescale 1ns/1ps
module psum_acc
    import psum_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pvalid,
    input  logic [ROWS*PSUM_WIDTH-1:0] psum_in,
    input  logic [ROWS-1:0]            row_mask,
    input  logic                       ic_done,
    input  logic                       oc_done,
    input  logic                       conv_done,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ROWS*PSUM_WIDTH-1:0] out_data,
    output logic [COL_W-1:0]           out_col,
    output logic [ROWS-1:0]            out_row_mask,
    output logic                       out_last,
    output logic                       out_conv_last,
    output logic                       busy,
    output logic                       err_ovf
);
    // mk_pipe[i] holds the markers delayed by i cycles
    mark_t mk_pipe [1:MARK_LAT];
    mark_t mk_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i <= MARK_LAT; i++)
                mk_pipe[i] <= '0;
        end else begin
            mk_pipe[1] <= {conv_done, oc_done, ic_done};
            for (int i = 2; i <= MARK_LAT; i++)
                mk_pipe[i] <= mk_pipe[i-1];
        end
    end

    assign mk_end = mk_pipe[MARK_LAT];

    logic [COL_W-1:0] wcol;
    logic             first;
    logic             wsel;
    logic             wrap;
    logic [CNT_W-1:0] nbeat;

    assign wrap  = pvalid && (wcol == COL_W'(TILE_LEN-1)) && !mk_end.ic;
    assign nbeat = {1'b0, wcol} + CNT_W'(pvalid);

    always_ff @(posedge clk) begin
        if (rst) begin
            wcol  <= '0;
            first <= 1'b1;
            wsel  <= 1'b0;
        end else begin
            if (mk_end.ic || wrap)
                wcol <= '0;
            else if (pvalid)
                wcol <= wcol + COL_W'(1);
            if (mk_end.oc)
                first <= 1'b1;
            else if (mk_end.ic)
                first <= 1'b0;
            if (mk_end.oc)
                wsel <= ~wsel;
        end
    end

    // wsel names the working bank; the other one is draining
    psum_beat_t       rd [2];
    psum_beat_t       beat_in;
    logic [COL_W-1:0] rcol;

    assign beat_in = psum_beat_t'(psum_in);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        psum_bank u_bank (
            .clk   (clk),
            .we    (pvalid && (wsel == 1'(b))),
            .acc   (~first),
            .waddr (wcol),
            .wdata (beat_in),
            .raddr (rcol),
            .rdata (rd[b])
        );
    end

    drain_st_t        st, st_nxt;
    logic [COL_W-1:0] rcol_nxt;
    logic [CNT_W-1:0] dlen;
    logic             conv_q;
    logic             xfer;
    logic             ovf_set;

    assign out_valid     = (st == D_DRAIN);
    assign busy          = out_valid;
    assign out_col       = rcol;
    assign out_last      = out_valid && ({1'b0, rcol} == dlen - CNT_W'(1));
    assign out_conv_last = out_last && conv_q;
    assign out_data      = out_valid ? rd[~wsel] : '0;
    assign xfer          = out_valid && out_ready;
    // a swap only overflows if beats remain after this cycle's transfer
    assign ovf_set       = (mk_end.oc && out_valid && !(xfer && out_last)) || wrap;

    always_comb begin
        st_nxt   = st;
        rcol_nxt = rcol;
        if (mk_end.oc) begin
            st_nxt   = (nbeat != '0) ? D_DRAIN : D_IDLE;
            rcol_nxt = '0;
        end else if (xfer) begin
            if (out_last) begin
                st_nxt   = D_IDLE;
                rcol_nxt = '0;
            end else begin
                rcol_nxt = rcol + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st           <= D_IDLE;
            rcol         <= '0;
            dlen         <= '0;
            out_row_mask <= '0;
            conv_q       <= 1'b0;
            err_ovf      <= 1'b0;
        end else begin
            st   <= st_nxt;
            rcol <= rcol_nxt;
            if (mk_end.oc) begin
                dlen         <= nbeat;
                out_row_mask <= row_mask;
                conv_q       <= mk_end.cv;
            end
            if (ovf_set)
                err_ovf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_psum_acc.sv
// Bench for psum_acc: scheduled beat/marker slots, behavioural column-sum
// model, drain scoreboard and handshake hold monitor.
`timescale 1ns/1ps
module tb_psum_acc;
    import psum_pkg::*;
    localparam int DW = ROWS*PSUM_WIDTH;

    logic            clk = 1'b0, rst = 1'b1, pvalid = 1'b0;
    logic            ic_done = 1'b0, oc_done = 1'b0, conv_done = 1'b0;
    logic [DW-1:0]   psum_in = '0;
    logic [ROWS-1:0] row_mask = '0;
    logic            out_ready = 1'b1;
    logic            out_valid, out_last, out_conv_last, busy, err_ovf;
    logic [DW-1:0]   out_data;
    logic [COL_W-1:0] out_col;
    logic [ROWS-1:0] out_row_mask;

    psum_acc dut (
        .clk(clk), .rst(rst), .pvalid(pvalid), .psum_in(psum_in), .row_mask(row_mask),
        .ic_done(ic_done), .oc_done(oc_done), .conv_done(conv_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_col(out_col), .out_row_mask(out_row_mask), .out_last(out_last),
        .out_conv_last(out_conv_last), .busy(busy), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic pv; logic [DW-1:0] d; logic ic, oc, cv; logic [ROWS-1:0] m;
    } slot_t;
    typedef struct {
        logic [DW-1:0] d; int col; logic last, cl; logic [ROWS-1:0] m;
    } obeat_t;
    typedef struct {
        int n_ic, nb; bit s2, tail; logic [ROWS-1:0] m; bit cv; int rm, kind, exp_n;
        logic [PSUM_WIDTH-1:0] r0;
    } vec_t;

    slot_t  sq[$];
    obeat_t got[$], expq[$];
    int     checks = 0, failures = 0;
    int     rmode = 0;
    bit     hold_en = 1'b1;

    task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(string name, logic act, logic exp);
        chk(name, DW'(act), DW'(exp));
    endtask

    // sink readiness pattern
    always @(posedge clk) begin
        #1;
        case (rmode)
            1:       out_ready = ~out_ready;
            2:       out_ready = 1'b0;
            3:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b1;
        endcase
    end

    // transfer capture and stall-hold checking
    logic             prev_stall = 1'b0;
    logic [DW-1:0]    prev_d = '0;
    logic [COL_W-1:0] prev_c = '0;
    logic             prev_l = 1'b0, prev_cl = 1'b0;
    always @(negedge clk) begin
        obeat_t o;
        if (hold_en && prev_stall && !rst) begin
            chk1("hold_valid", out_valid, 1'b1);
            chk("hold_data", out_data, prev_d);
            chk("hold_ctl", DW'({out_col, out_last, out_conv_last}), DW'({prev_c, prev_l, prev_cl}));
        end
        prev_stall = out_valid && !out_ready && !rst;
        prev_d = out_data; prev_c = out_col; prev_l = out_last; prev_cl = out_conv_last;
        if (out_valid && out_ready && !rst) begin
            o.d = out_data; o.col = int'(out_col); o.last = out_last;
            o.cl = out_conv_last; o.m = out_row_mask;
            got.push_back(o);
        end
    end

    // Builds slots for one output tile and the expected drain from column sums
    task automatic build_job(int n_ic, int nb, bit s2, bit tail, logic [ROWS-1:0] m, bit cv, int kind);
        psum_beat_t mdl [TILE_LEN];
        psum_beat_t v;
        slot_t      s;
        obeat_t     o;
        bit         lastp, lasts;
        for (int p = 0; p < n_ic; p++) begin
            lastp = (p == n_ic - 1);
            for (int b = 0; b < nb; b++) begin
                for (int r = 0; r < ROWS; r++)
                    case (kind)
                        0:       v[r] = PSUM_WIDTH'(p + r);
                        1:       v[r] = PSUM_WIDTH'($urandom);
                        2:       v[r] = (p == 0) ? 24'h7fffff : 24'h000001;
                        default: v[r] = 24'd5;
                    endcase
                if (p == 0) mdl[b] = v;
                else for (int r = 0; r < ROWS; r++) mdl[b][r] = mdl[b][r] + v[r];
                lasts = (b == nb - 1) && !tail;
                s.pv = 1'b1; s.d = v; s.m = m;
                s.ic = lasts; s.oc = lasts && lastp; s.cv = lasts && lastp && cv;
                sq.push_back(s);
                if (s2 && b != nb - 1) begin
                    s.pv = 1'b0; s.d = '0; s.ic = 1'b0; s.oc = 1'b0; s.cv = 1'b0;
                    sq.push_back(s);
                end
            end
            if (tail) begin
                s.pv = 1'b0; s.d = '0; s.m = m;
                s.ic = 1'b1; s.oc = lastp; s.cv = lastp && cv;
                sq.push_back(s);
            end
        end
        for (int b = 0; b < nb; b++) begin
            o.d = mdl[b]; o.col = b; o.last = (b == nb - 1);
            o.cl = cv && (b == nb - 1); o.m = m;
            expq.push_back(o);
        end
    endtask

    // Markers are issued MARK_LAT cycles ahead of the slot they close
    task automatic play();
        int n = sq.size();
        for (int t = -MARK_LAT; t < n; t++) begin
            if (t >= 0) begin
                pvalid = sq[t].pv; psum_in = sq[t].d; row_mask = sq[t].m;
            end
            if (t + MARK_LAT < n) begin
                ic_done = sq[t+MARK_LAT].ic; oc_done = sq[t+MARK_LAT].oc;
                conv_done = sq[t+MARK_LAT].cv;
            end else begin
                ic_done = 1'b0; oc_done = 1'b0; conv_done = 1'b0;
            end
            @(posedge clk); #1;
        end
        pvalid = 1'b0; psum_in = '0; ic_done = 1'b0; oc_done = 1'b0; conv_done = 1'b0;
        sq.delete();
    endtask

    task automatic drain_check(string tag);
        int guard = 0;
        @(posedge clk); #1;
        while ((busy || got.size() < expq.size()) && guard < 400) begin
            @(posedge clk); #1;
            guard++;
        end
        chk1({tag, "_timeout"}, guard >= 400, 1'b0);
        chk({tag, "_count"}, DW'(got.size()), DW'(expq.size()));
        for (int i = 0; i < expq.size() && i < got.size(); i++) begin
            chk({tag, "_data"}, got[i].d, expq[i].d);
            chk({tag, "_meta"}, DW'({8'(got[i].col), got[i].last, got[i].cl, got[i].m}),
                DW'({8'(expq[i].col), expq[i].last, expq[i].cl, expq[i].m}));
        end
    endtask

    initial begin : main
        vec_t          tbl [5];
        logic [DW-1:0] tmp;
        slot_t         s;
        obeat_t        o;

        tbl[0] = '{4, 16, 0, 0, 8'hff, 0, 0, 0, 16, 24'd6};
        tbl[1] = '{1, 10, 0, 1, 8'h1f, 0, 0, 0, 10, 24'd0};
        tbl[2] = '{1,  8, 1, 0, 8'hff, 0, 0, 0,  8, 24'd0};
        tbl[3] = '{2,  4, 0, 0, 8'hff, 0, 1, 2,  4, 24'h800000};
        tbl[4] = '{3, 12, 1, 1, 8'h5a, 1, 3, 1, 12, 24'd0};

        repeat (3) @(posedge clk);
        #1;
        chk1("rst_valid", out_valid, 1'b0);
        chk1("rst_last", out_last, 1'b0);
        chk1("rst_conv_last", out_conv_last, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_err", err_ovf, 1'b0);
        chk("rst_col", DW'(out_col), '0);
        chk("rst_mask", DW'(out_row_mask), '0);
        chk("rst_data", out_data, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            rmode = tbl[i].rm;
            build_job(tbl[i].n_ic, tbl[i].nb, tbl[i].s2, tbl[i].tail, tbl[i].m, tbl[i].cv, tbl[i].kind);
            play();
            chk1($sformatf("tbl%0d_valid_rise", i), out_valid, 1'b1);
            drain_check($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_nbeats", i), DW'(got.size()), DW'(tbl[i].exp_n));
            if (tbl[i].kind != 1 && got.size() > 0) begin
                tmp = got[0].d;
                chk($sformatf("tbl%0d_r0c0", i), DW'(tmp[PSUM_WIDTH-1:0]), DW'(tbl[i].r0));
            end
            got.delete(); expq.delete();
            rmode = 0;
        end

        for (int k = 0; k < 6; k++) begin
            int nb;
            nb = $urandom_range(1, TILE_LEN);
            case ($urandom_range(0, 2))
                0:       rmode = 0;
                1:       rmode = 1;
                default: rmode = 3;
            endcase
            build_job($urandom_range(1, 4), nb, 1'($urandom_range(0, 1)),
                      (nb < TILE_LEN) ? 1'($urandom_range(0, 1)) : 1'b0,
                      ROWS'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 1));
            play();
            drain_check($sformatf("rnd%0d", k));
            got.delete(); expq.delete();
            rmode = 0;
        end
        chk1("no_err_yet", err_ovf, 1'b0);

        // pass with no beats at all: nothing drains
        s.pv = 1'b0; s.d = '0; s.m = 8'h0f; s.ic = 1'b1; s.oc = 1'b1; s.cv = 1'b0;
        sq.push_back(s);
        play();
        chk1("empty_valid", out_valid, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("empty_count", DW'(got.size()), '0);
        chk1("empty_err", err_ovf, 1'b0);

        // second swap while the first bank is still stalled
        hold_en = 1'b0; rmode = 2;
        @(posedge clk); #1;
        build_job(1, 6, 0, 0, 8'hff, 0, 1);
        expq.delete();
        play();
        build_job(1, 5, 0, 0, 8'h3c, 0, 1);
        play();
        chk1("ovf_flag", err_ovf, 1'b1);
        chk("ovf_no_xfer", DW'(got.size()), '0);
        rmode = 0;
        drain_check("ovf");
        chk1("ovf_sticky", err_ovf, 1'b1);
        got.delete(); expq.delete();
        hold_en = 1'b1;

        // reset after one closed ic pass and a few accumulated beats
        build_job(2, 6, 0, 0, 8'hff, 0, 1);
        expq.delete();
        while (sq.size() > 9) void'(sq.pop_back());
        play();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst2_err_clear", err_ovf, 1'b0);
        chk1("rst2_valid", out_valid, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        build_job(1, 4, 0, 0, 8'h0f, 1, 3);
        play();
        drain_check("rst2");
        got.delete(); expq.delete();
        chk1("rst2_err_after", err_ovf, 1'b0);

        // 17 beats in one pass: write column wraps
        for (int k = 0; k < TILE_LEN + 1; k++) begin
            s.pv = 1'b1; s.d = {DW/32{$urandom}}; s.m = 8'hff;
            s.ic = (k == TILE_LEN); s.oc = (k == TILE_LEN); s.cv = 1'b0;
            sq.push_back(s);
        end
        o.d = s.d; o.col = 0; o.last = 1'b1; o.cl = 1'b0; o.m = 8'hff;
        expq.push_back(o);
        play();
        chk1("wcol_wrap_err", err_ovf, 1'b1);
        drain_check("wcol_wrap");
        got.delete(); expq.delete();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
